// File: rtl/laser_shot_pkg.sv
// laser_shot_pkg
// Definitions shared by the display path: colour codes driven to the colour
// mixer and the screen/ship geometry that the spaceship block and the laser
// block must agree on.
package laser_shot_pkg;

    typedef enum logic [2:0] {
        BACKGROUND = 3'd0,
        SPACESHIP  = 3'd1,
        ALIENS0    = 3'd2,
        ALIENS1    = 3'd3,
        ALIENS2    = 3'd4,
        ALIENS3    = 3'd5,
        LASER      = 3'd6,
        NONE       = 3'd7
    } color_t;

    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;
    localparam int SHIP_HEIGHT   = 30;
    localparam int V_OFFSET      = 10;

endpackage

// File: rtl/laser_shot_rise_detect.sv
// rise_detect
// One-flop rising-edge detector.
// Ports:
//   clk   - clock
//   reset - asynchronous, active-high; clears the history flop
//   d     - level input (already synchronous to clk)
//   rise  - high for the cycle in which d is 1 and was 0 on the previous clock
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    // History clears to 0, so a level already high at reset release counts
    // as an edge on the first clock.
    assign rise = d & ~d_q;

endmodule

// File: rtl/laser_shot.sv
// laser_shot
// Player laser: launches one bolt from just above the ship's nose on a fire
// press, moves it up once per frame, ends it at the top of the screen or on a
// hit, then holds off re-fire for a few frames. Paints the bolt as LASER.
// Ports:
//   clk         - system/pixel clock
//   reset       - asynchronous, active-high
//   fire        - fire button level; rising edge requests a shot
//   hit         - one-cycle collision pulse from the alien block
//   gunPosition - ship centre x, captured at launch
//   hPos, vPos  - current pixel coordinates
//   active      - bolt in flight
//   laserX      - bolt centre x (held after the bolt ends)
//   laserY      - bolt top y (held after the bolt ends)
//   color       - LASER on a bolt pixel, otherwise BACKGROUND
module laser_shot
    import laser_shot_pkg::*;
#(
    parameter int SCREEN_WIDTH    = laser_shot_pkg::SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT   = laser_shot_pkg::SCREEN_HEIGHT,
    parameter int SHIP_HEIGHT     = laser_shot_pkg::SHIP_HEIGHT,
    parameter int V_OFFSET        = laser_shot_pkg::V_OFFSET,
    parameter int LASER_WIDTH     = 4,
    parameter int LASER_HEIGHT    = 12,
    parameter int LASER_STEP      = 8,
    parameter int COOLDOWN_FRAMES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fire,
    input  logic       hit,
    input  logic [9:0] gunPosition,
    input  logic [9:0] hPos,
    input  logic [9:0] vPos,
    output logic       active,
    output logic [9:0] laserX,
    output logic [9:0] laserY,
    output logic [2:0] color
);

    // state    | meaning
    // IDLE     | no bolt; a fire edge launches one
    // FLYING   | bolt in flight, moves up each frame tick
    // COOLDOWN | bolt ended; counting frames before re-fire is allowed
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLYING   = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    localparam logic [9:0]  LAUNCH_Y = 10'(SCREEN_HEIGHT - V_OFFSET - SHIP_HEIGHT - LASER_HEIGHT);
    localparam logic [9:0]  STEP     = 10'(LASER_STEP);
    localparam logic [7:0]  CD_LAST  = 8'(COOLDOWN_FRAMES - 1);
    localparam logic [10:0] HALF_W   = 11'(LASER_WIDTH / 2);
    localparam logic [10:0] HEIGHT   = 11'(LASER_HEIGHT);

    if (SCREEN_WIDTH > 1024 || SCREEN_HEIGHT > 1023 || (LASER_WIDTH % 2) != 0
        || COOLDOWN_FRAMES < 1 || COOLDOWN_FRAMES > 256) begin : g_bad_params
        $error("laser_shot: unsupported parameter set");
    end

    state_t     state, state_n;
    logic [9:0] laser_x_n, laser_y_n;
    logic [7:0] cd_cnt, cd_cnt_n;
    logic       fire_edge;
    logic       frame_tick;
    logic       vblank;

    assign vblank = (vPos >= 10'(SCREEN_HEIGHT));

    rise_detect u_fire_edge (
        .clk   (clk),
        .reset (reset),
        .d     (fire),
        .rise  (fire_edge)
    );

    rise_detect u_frame_tick (
        .clk   (clk),
        .reset (reset),
        .d     (vblank),
        .rise  (frame_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            laserX <= '0;
            laserY <= '0;
            cd_cnt <= '0;
        end else begin
            state  <= state_n;
            laserX <= laser_x_n;
            laserY <= laser_y_n;
            cd_cnt <= cd_cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        laser_x_n = laserX;
        laser_y_n = laserY;
        cd_cnt_n  = cd_cnt;
        case (state)
            IDLE: begin
                // A frame tick on the launch cycle is deliberately ignored.
                if (fire_edge) begin
                    state_n   = FLYING;
                    laser_x_n = gunPosition;
                    laser_y_n = LAUNCH_Y;
                end
            end
            FLYING: begin
                if (hit) begin
                    state_n  = COOLDOWN;
                    cd_cnt_n = '0;
                end else if (frame_tick) begin
                    if (laserY < STEP) begin
                        state_n  = COOLDOWN;
                        cd_cnt_n = '0;
                    end else begin
                        laser_y_n = laserY - STEP;
                    end
                end
            end
            COOLDOWN: begin
                if (frame_tick) begin
                    if (cd_cnt == CD_LAST) begin
                        state_n  = IDLE;
                        cd_cnt_n = '0;
                    end else begin
                        cd_cnt_n = cd_cnt + 8'd1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Derived from the state flop so reset clears it asynchronously.
    assign active = (state == FLYING);

    // Bounds rearranged to additions in 11 bits so nothing can wrap:
    //   laserX - W/2 <= hPos  <=>  laserX <= hPos + W/2
    //   hPos <= laserX + W/2 - 1  <=>  hPos < laserX + W/2
    logic [10:0] h11, v11, x11, y11;
    logic        in_x, in_y;

    always_comb begin
        h11   = {1'b0, hPos};
        v11   = {1'b0, vPos};
        x11   = {1'b0, laserX};
        y11   = {1'b0, laserY};
        in_x  = (x11 <= h11 + HALF_W) && (h11 < x11 + HALF_W);
        in_y  = (y11 <= v11) && (v11 < y11 + HEIGHT);
        color = (active && in_x && in_y) ? LASER : BACKGROUND;
    end

endmodule

// File: tb/tb_laser_shot.sv
module tb_laser_shot;

    logic       clk = 1'b0;
    logic       reset;
    logic       fire;
    logic       hit;
    logic [9:0] gunPosition;
    logic [9:0] hPos;
    logic [9:0] vPos;
    logic       active;
    logic [9:0] laserX;
    logic [9:0] laserY;
    logic [2:0] color;

    int checks = 0;
    int failures = 0;

    laser_shot dut (
        .clk         (clk),
        .reset       (reset),
        .fire        (fire),
        .hit         (hit),
        .gunPosition (gunPosition),
        .hPos        (hPos),
        .vPos        (vPos),
        .active      (active),
        .laserX      (laserX),
        .laserY      (laserY),
        .color       (color)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        vPos = 10'd480;
        step();
        vPos = 10'd0;
        step();
    endtask

    // Reference model: a bolt is "waiting" when not active and
    // m_wait frames of cooldown remain.
    int m_active, m_x, m_y, m_wait, m_fprev, m_vbprev;

    task automatic model_reset();
        m_active = 0; m_x = 0; m_y = 0; m_wait = 0; m_fprev = 0; m_vbprev = 0;
    endtask

    function automatic int model_color(int h, int v);
        if (m_active != 0 && h >= m_x - 2 && h <= m_x + 1 && v >= m_y && v <= m_y + 11)
            return 6;
        return 0;
    endfunction

    task automatic model_clock(input int f, input int hi, input int g, input int v);
        int fe, ft, vb;
        vb = (v >= 480) ? 1 : 0;
        fe = (f != 0 && m_fprev == 0) ? 1 : 0;
        ft = (vb != 0 && m_vbprev == 0) ? 1 : 0;
        if (m_active != 0) begin
            if (hi != 0) begin
                m_active = 0; m_wait = 4;
            end else if (ft != 0) begin
                if (m_y < 8) begin
                    m_active = 0; m_wait = 4;
                end else begin
                    m_y = m_y - 8;
                end
            end
        end else if (m_wait > 0) begin
            if (ft != 0) m_wait = m_wait - 1;
        end else if (fe != 0) begin
            m_active = 1; m_x = g; m_y = 480 - 10 - 30 - 12;
        end
        m_fprev = f;
        m_vbprev = vb;
    endtask

    typedef struct {
        int h;
        int v;
        int exp_color;
    } pix_vec_t;

    pix_vec_t pix_tbl[8];

    initial begin
        pix_tbl[0] = '{318, 428, 6};
        pix_tbl[1] = '{321, 439, 6};
        pix_tbl[2] = '{322, 428, 0};
        pix_tbl[3] = '{317, 428, 0};
        pix_tbl[4] = '{320, 427, 0};
        pix_tbl[5] = '{320, 440, 0};
        pix_tbl[6] = '{319, 433, 6};
        pix_tbl[7] = '{100, 100, 0};

        reset = 1'b1; fire = 1'b0; hit = 1'b0;
        gunPosition = 10'd320; hPos = 10'd0; vPos = 10'd0;
        #1;
        chk("reset_active", active, 0);
        chk("reset_laserX", laserX, 0);
        chk("reset_laserY", laserY, 0);
        chk("reset_color", color, 0);
        step();
        reset = 1'b0;
        step();

        // Launch and pixel table
        fire = 1'b1;
        step();
        chk("launch_active", active, 1);
        chk("launch_laserX", laserX, 320);
        chk("launch_laserY", laserY, 428);
        fire = 1'b0;
        for (int i = 0; i < 8; i++) begin
            hPos = 10'(pix_tbl[i].h);
            vPos = 10'(pix_tbl[i].v);
            #1;
            chk($sformatf("pix_%0d_%0d", pix_tbl[i].h, pix_tbl[i].v), color, pix_tbl[i].exp_color);
            step();
        end
        hPos = 10'd0; vPos = 10'd0;
        step();

        // Full flight; ship moves but bolt x stays put
        gunPosition = 10'd100;
        for (int i = 0; i < 53; i++) tick();
        chk("flight_laserY_53", laserY, 4);
        chk("flight_active_53", active, 1);
        chk("flight_laserX_frozen", laserX, 320);
        tick();
        chk("flight_active_54", active, 0);
        chk("flight_laserY_held", laserY, 4);
        for (int k = 0; k < 4; k++) begin
            fire = 1'b1;
            step();
            chk($sformatf("cooldown_fire_ignored_%0d", k), active, 0);
            fire = 1'b0;
            step();
            tick();
        end
        fire = 1'b1;
        step();
        chk("refire_active", active, 1);
        chk("refire_laserX", laserX, 100);
        chk("refire_laserY", laserY, 428);
        fire = 1'b0;
        step();

        // Hit coincident with a frame tick at laserY=300
        for (int i = 0; i < 16; i++) tick();
        chk("pre_hit_laserY", laserY, 300);
        hit = 1'b1; vPos = 10'd480;
        step();
        hit = 1'b0; vPos = 10'd0;
        chk("hit_active", active, 0);
        chk("hit_laserY", laserY, 300);
        step();
        hit = 1'b1;
        step();
        hit = 1'b0;
        repeat (4) tick();

        // Held fire never relaunches until it goes low and high again
        gunPosition = 10'd320;
        fire = 1'b1;
        step();
        chk("hold_launch", active, 1);
        hit = 1'b1;
        step();
        hit = 1'b0;
        repeat (4) tick();
        repeat (3) step();
        chk("hold_no_relaunch", active, 0);
        fire = 1'b0;
        step();
        fire = 1'b1;
        step();
        chk("hold_relaunch", active, 1);
        fire = 1'b0;

        // Asynchronous reset mid-flight
        tick();
        hPos = 10'd320; vPos = laserY;
        #1;
        chk("prereset_color", color, 6);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("async_reset_active", active, 0);
        chk("async_reset_color", color, 0);
        #3;
        reset = 1'b0;
        hPos = 10'd0; vPos = 10'd0;
        step();
        gunPosition = 10'd50;
        fire = 1'b1;
        step();
        chk("post_reset_active", active, 1);
        chk("post_reset_laserX", laserX, 50);
        fire = 1'b0;

        // Randomised run against the reference model
        reset = 1'b1; fire = 1'b0; hit = 1'b0; vPos = 10'd0; hPos = 10'd0;
        model_reset();
        step();
        reset = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            int r, t;
            if ($urandom_range(0, 3) == 0) fire = ~fire;
            hit = ($urandom_range(0, 19) == 0);
            gunPosition = 10'($urandom_range(0, 639));
            r = $urandom_range(0, 9);
            if (r < 2) begin
                vPos = 10'(480 + $urandom_range(0, 44));
            end else if (r < 6) begin
                t = m_y + $urandom_range(0, 13) - 1;
                if (t < 0) t = 0;
                vPos = 10'(t);
            end else begin
                vPos = 10'($urandom_range(0, 479));
            end
            if ($urandom_range(0, 1) == 0) begin
                t = m_x + $urandom_range(0, 5) - 3;
                if (t < 0) t = 0;
                hPos = 10'(t);
            end else begin
                hPos = 10'($urandom_range(0, 639));
            end
            #1;
            chk("rand_color", color, model_color(hPos, vPos));
            @(posedge clk);
            model_clock(fire, hit, gunPosition, vPos);
            #1;
            chk("rand_active", active, m_active);
            chk("rand_laserX", laserX, m_x);
            chk("rand_laserY", laserY, m_y);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
